// File: rtl/snake_pkg.sv
// Shared arbiter definitions: FSM encoding, active-video line count, starvation limit.
// No logic here; imported by snake_body_arbiter and snake_prio_sel.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GFX         = 2'd1,
    GAME        = 2'd2,
    GAME_LOCKED = 2'd3
  } arb_state_t;

  localparam int V_ACTIVE_LINES = 480;

  localparam int              STARVE_CNT_W = 4;
  localparam logic [3:0]      STARVE_LIMIT = 4'd8;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_GFX  = 0;
  localparam int GNT_GAME = 1;

endpackage

// File: rtl/snake_prio_sel.sv
// One-hot grant selection for the segment RAM; purely combinational, zero latency.
// A locked game burst excludes gfx; starvation relief or blanking favours game, active video favours gfx.
module snake_prio_sel
  import snake_pkg::*;
(
  input  logic       active,
  input  logic       gfx_req,
  input  logic       game_req,
  input  logic       locked,
  input  logic       starve,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (locked) begin
      gnt[GNT_GAME] = game_req;
    end else if (starve && game_req) begin
      gnt[GNT_GAME] = 1'b1;
    end else if (gfx_req && game_req) begin
      if (active) gnt[GNT_GFX]  = 1'b1;
      else        gnt[GNT_GAME] = 1'b1;
    end else begin
      gnt[GNT_GFX]  = gfx_req;
      gnt[GNT_GAME] = game_req;
    end
  end

endmodule

// File: rtl/snake_body_arbiter.sv
// Arbitrates gfx/game access to a 1-cycle-latency segment RAM; grants same cycle, valid one cycle later.
// Losers simply wait (req held); optional STARVE_GUARD_EN forces one game grant after 8 gfx grants.
module snake_body_arbiter
  import snake_pkg::*;
#(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int ADDR_W            = 4,
  parameter int COORD_W           = 7,
  parameter int V_ACTIVE          = V_ACTIVE_LINES
) (
  input  logic                     clock_25,
  input  logic                     reset,
  input  logic [PIXEL_DISPLAY_BIT:0] X,
  input  logic [PIXEL_DISPLAY_BIT:0] Y,
  input  logic                     gfx_req,
  input  logic [ADDR_W-1:0]        gfx_addr,
  output logic                     gfx_gnt,
  output logic                     gfx_valid,
  input  logic                     game_req,
  input  logic                     game_lock,
  input  logic                     game_we,
  input  logic [ADDR_W-1:0]        game_addr,
  input  logic [2*COORD_W-1:0]     game_wdata,
  output logic                     game_gnt,
  output logic                     game_valid,
  output logic [2*COORD_W-1:0]     rdata,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [2*COORD_W-1:0]     ram_wdata,
  input  logic [2*COORD_W-1:0]     ram_rdata,
  output logic                     semaforo
);

  localparam logic [PIXEL_DISPLAY_BIT:0] V_ACTIVE_Y = V_ACTIVE[PIXEL_DISPLAY_BIT:0];

  arb_state_t state;
  logic       lock_armed;
  logic       locked;
  logic       active;
  logic       game_req_eff;
  logic       starve;
  logic [1:0] gnt_raw;
  logic       unused_x;

  assign unused_x = ^X;
  assign locked   = (state == GAME_LOCKED);
  assign active   = (Y < V_ACTIVE_Y);
  // The cycle game_lock drops ends the burst with no grant, so the FSM lands in IDLE.
  assign game_req_eff = game_req & ~(locked & ~game_lock);

`ifdef STARVE_GUARD_EN
  logic [STARVE_CNT_W-1:0] starve_cnt;

  assign starve = (starve_cnt == STARVE_LIMIT);

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (gfx_gnt && game_req && !game_lock) begin
      starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  assign starve = 1'b0;
`endif

  snake_prio_sel u_prio_sel (
    .active   (active),
    .gfx_req  (gfx_req),
    .game_req (game_req_eff),
    .locked   (locked),
    .starve   (starve),
    .gnt      (gnt_raw)
  );

  assign gfx_gnt   = gnt_raw[GNT_GFX]  & ~reset;
  assign game_gnt  = gnt_raw[GNT_GAME] & ~reset;
  assign ram_we    = game_gnt & game_we;
  assign ram_wdata = game_gnt ? game_wdata : '0;
  assign rdata     = (gfx_valid | game_valid) ? ram_rdata : '0;

  always_comb begin
    ram_addr = '0;
    if (gfx_gnt)       ram_addr = gfx_addr;
    else if (game_gnt) ram_addr = game_addr;
  end

  // lock_armed stays low after reset until game_lock is seen low, so a lock held
  // across reset cannot silently resume its burst.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      semaforo   <= 1'b0;
      gfx_valid  <= 1'b0;
      game_valid <= 1'b0;
      lock_armed <= 1'b0;
    end else begin
      gfx_valid  <= gfx_gnt;
      game_valid <= game_gnt & ~game_we;
      if (!game_lock) lock_armed <= 1'b1;

      if (state == GAME_LOCKED) begin
        if (!game_lock) begin
          state    <= IDLE;
          semaforo <= 1'b0;
        end
      end else if (game_gnt && game_lock && lock_armed) begin
        state    <= GAME_LOCKED;
        semaforo <= 1'b1;
      end else if (game_gnt) begin
        state <= GAME;
      end else if (gfx_gnt) begin
        state <= GFX;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_arbiter.sv
// Self-checking bench: behavioural owner/lock model compared every cycle, plus directed literal checks.
module tb_snake_body_arbiter;

`ifdef STARVE_GUARD_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  logic        clock_25 = 1'b0;
  logic        reset;
  logic [9:0]  X, Y;
  logic        gfx_req, gfx_gnt, gfx_valid;
  logic [3:0]  gfx_addr;
  logic        game_req, game_lock, game_we, game_gnt, game_valid;
  logic [3:0]  game_addr;
  logic [13:0] game_wdata;
  logic [13:0] rdata;
  logic [3:0]  ram_addr;
  logic        ram_we;
  logic [13:0] ram_wdata;
  logic [13:0] ram_rdata;
  logic        semaforo;

  always #5 clock_25 = ~clock_25;

  snake_body_arbiter dut (
    .clock_25   (clock_25),
    .reset      (reset),
    .X          (X),
    .Y          (Y),
    .gfx_req    (gfx_req),
    .gfx_addr   (gfx_addr),
    .gfx_gnt    (gfx_gnt),
    .gfx_valid  (gfx_valid),
    .game_req   (game_req),
    .game_lock  (game_lock),
    .game_we    (game_we),
    .game_addr  (game_addr),
    .game_wdata (game_wdata),
    .game_gnt   (game_gnt),
    .game_valid (game_valid),
    .rdata      (rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .semaforo   (semaforo)
  );

  // Environment RAM: single port, synchronous read.
  logic [13:0] ram [16];
  always @(posedge clock_25) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the RAM this cycle, and what the previous read returns.
  bit          m_locked, m_armed, m_vg, m_vm;
  int          m_cnt;
  logic [13:0] m_rd;
  logic [13:0] m_mem [16];
  bit          cmp_on = 1'b0;

  task automatic model_cycle();
    int w;
    bit act_region;
    if (reset) begin
      chk("rst_gfx_gnt", gfx_gnt, 0);
      chk("rst_game_gnt", game_gnt, 0);
      chk("rst_gfx_valid", gfx_valid, 0);
      chk("rst_game_valid", game_valid, 0);
      chk("rst_semaforo", semaforo, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_rdata", rdata, 0);
      m_locked = 0; m_armed = 0; m_cnt = 0; m_vg = 0; m_vm = 0;
      return;
    end
    chk("gfx_valid", gfx_valid, m_vg);
    chk("game_valid", game_valid, m_vm);
    chk("rdata", rdata, (m_vg | m_vm) ? m_rd : 14'd0);

    act_region = (Y < 10'd480);
    if (m_locked)                                w = (game_lock && game_req) ? 2 : 0;
    else if (STARVE && m_cnt == 8 && game_req)   w = 2;
    else if (gfx_req && game_req)                w = act_region ? 1 : 2;
    else if (gfx_req)                            w = 1;
    else if (game_req)                           w = 2;
    else                                         w = 0;

    chk("gfx_gnt", gfx_gnt, w == 1);
    chk("game_gnt", game_gnt, w == 2);
    chk("ram_addr", ram_addr, (w == 1) ? gfx_addr : (w == 2) ? game_addr : 4'd0);
    chk("ram_we", ram_we, (w == 2) && game_we);
    chk("ram_wdata", ram_wdata, (w == 2) ? game_wdata : 14'd0);
    chk("semaforo", semaforo, m_locked);

    m_vg = (w == 1);
    m_vm = (w == 2) && !game_we;
    if (w == 1) m_rd = m_mem[gfx_addr];
    if (w == 2) m_rd = m_mem[game_addr];
    if (w == 2 && game_we) m_mem[game_addr] = game_wdata;
    m_cnt = (STARVE && w == 1 && game_req && !game_lock) ? m_cnt + 1 : 0;
    if (m_locked) m_locked = game_lock;
    else          m_locked = (w == 2) && game_lock && m_armed;
    if (!game_lock) m_armed = 1;
  endtask

  initial forever begin
    @(negedge clock_25);
    if (cmp_on) model_cycle();
  end

  task automatic step();
    @(posedge clock_25);
    #1;
  endtask

  task automatic mid();
    @(negedge clock_25);
    #1;
  endtask

  task automatic clear_reqs();
    gfx_req = 0; game_req = 0; game_lock = 0; game_we = 0;
  endtask

  initial begin
    int nz, sem, gfx_seen, nwr, pulses, first, last, gap_bad;
    for (int i = 0; i < 16; i++) begin
      ram[i]   = 14'(i * 37 + 5);
      m_mem[i] = 14'(i * 37 + 5);
    end
    reset = 1; X = 0; Y = 0;
    clear_reqs();
    gfx_addr = 0; game_addr = 0; game_wdata = 0;
    cmp_on = 1;

    // Grants held off while reset is high.
    gfx_req = 1;
    mid();
    chk("lit_rst_gfx_gnt", gfx_gnt, 0);
    chk("lit_rst_semaforo", semaforo, 0);
    chk("lit_rst_ram_addr", ram_addr, 0);
    step(); gfx_req = 0;
    step(); reset = 0;

    nz = 0;
    repeat (100) begin
      mid();
      if (ram_we || ram_addr != 0 || gfx_gnt || game_gnt) nz++;
    end
    chk("lit_idle_quiet", nz, 0);

    // Active video: gfx wins, reads RAM[3] = 3*37+5.
    step(); Y = 100; gfx_req = 1; game_req = 1; gfx_addr = 3; game_addr = 7; game_we = 0;
    mid();
    chk("lit_act_gfx_gnt", gfx_gnt, 1);
    chk("lit_act_game_gnt", game_gnt, 0);
    chk("lit_act_ram_addr", ram_addr, 3);
    step(); clear_reqs();
    mid();
    chk("lit_act_gfx_valid", gfx_valid, 1);
    chk("lit_act_rdata", rdata, 14'd116);

    // Blanking: game wins and writes, no valid.
    step(); Y = 490; gfx_req = 1; game_req = 1; game_we = 1; game_addr = 5; game_wdata = 14'h0102;
    mid();
    chk("lit_blank_game_gnt", game_gnt, 1);
    chk("lit_blank_gfx_gnt", gfx_gnt, 0);
    chk("lit_blank_ram_we", ram_we, 1);
    step(); clear_reqs();
    mid();
    chk("lit_wr_game_valid", game_valid, 0);
    chk("lit_wr_gfx_valid", gfx_valid, 0);
    chk("lit_wr_ram5", ram[5], 14'h0102);
    step(); game_req = 1; game_addr = 5;
    mid();
    step(); game_req = 0;
    mid();
    chk("lit_rb_game_valid", game_valid, 1);
    chk("lit_rb_rdata", rdata, 14'h0102);

    // Locked burst of 4 writes starting at Y=479, crossing into blanking.
    step(); Y = 479; game_req = 1; game_lock = 1; game_we = 1; game_addr = 8; game_wdata = 14'h0aa0;
    sem = 0; gfx_seen = 0; nwr = 0;
    for (int c = 0; c < 7; c++) begin
      mid();
      if (c == 0) chk("lit_lock_start_gnt", game_gnt, 1);
      if (c == 5) chk("lit_lock_after_gfx", gfx_gnt, 1);
      sem += int'(semaforo);
      nwr += int'(ram_we);
      if (c <= 4) gfx_seen += int'(gfx_gnt);
      step();
      gfx_req = 1;
      if (c + 1 >= 2) Y = 480;
      if (c + 1 <= 3) begin
        game_addr  = 4'(8 + c + 1);
        game_wdata = 14'(16'h0aa0 + c + 1);
      end else begin
        game_lock = 0; game_req = 0; game_we = 0;
      end
    end
    chk("lit_lock_sem_cycles", sem, 4);
    chk("lit_lock_gfx_blocked", gfx_seen, 0);
    chk("lit_lock_writes", nwr, 4);

    // Reset in the 2nd cycle of a locked burst.
    clear_reqs(); Y = 200;
    game_req = 1; game_lock = 1; game_we = 1; game_addr = 2; game_wdata = 14'h0033;
    mid();
    chk("lit_rb_lock_gnt", game_gnt, 1);
    step(); game_addr = 3;
    #1;
    chk("lit_rb_sem_before", semaforo, 1);
    reset = 1;
    #1;
    chk("lit_async_game_gnt", game_gnt, 0);
    chk("lit_async_semaforo", semaforo, 0);
    chk("lit_async_ram_we", ram_we, 0);
    chk("lit_async_ram_addr", ram_addr, 0);
    chk("lit_async_ram_wdata", ram_wdata, 0);
    chk("lit_async_rdata", rdata, 0);
    step(); step();
    reset = 0; game_req = 0; game_we = 0;
    mid();
    chk("lit_post_game_gnt", game_gnt, 0);
    chk("lit_post_semaforo", semaforo, 0);
    step(); game_req = 1; game_addr = 4;
    mid();
    chk("lit_post_unlocked_gnt", game_gnt, 1);
    step(); game_req = 0;
    mid();
    chk("lit_post_no_relock", semaforo, 0);
    step(); game_lock = 0;
    step(); game_lock = 1; game_req = 1; game_we = 1;
    step(); game_req = 0; game_we = 0;
    mid();
    chk("lit_relock_sem", semaforo, 1);
    step(); game_lock = 0;
    step();
    mid();
    chk("lit_unlock_sem", semaforo, 0);

    // Randomised traffic with boundary-heavy Y values.
    for (int n = 0; n < 3000; n++) begin
      step();
      reset    = ($urandom_range(0, 499) == 0);
      X        = 10'($urandom_range(0, 799));
      gfx_req  = ($urandom_range(0, 99) < 60);
      game_req = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 7) == 0) game_lock = ~game_lock;
      game_we    = 1'($urandom);
      gfx_addr   = 4'($urandom);
      game_addr  = 4'($urandom);
      game_wdata = 14'($urandom);
      case ($urandom_range(0, 5))
        0: Y = 10'd479;
        1: Y = 10'd480;
        2: Y = 10'd0;
        3: Y = 10'd524;
        default: Y = 10'($urandom_range(0, 524));
      endcase
    end
    step(); reset = 0; clear_reqs();
    step();

`ifdef STARVE_GUARD_EN
    Y = 50; gfx_req = 1; game_req = 1; game_lock = 0; game_we = 0;
    pulses = 0; first = -1; last = -1; gap_bad = 0;
    for (int c = 0; c < 36; c++) begin
      mid();
      if (game_gnt) begin
        pulses++;
        if (last >= 0 && c - last != 9) gap_bad++;
        if (first < 0) first = c;
        last = c;
      end
      step();
    end
    chk("lit_starve_pulses", pulses, 4);
    chk("lit_starve_first", first, 8);
    chk("lit_starve_gap", gap_bad, 0);
    clear_reqs();
    step();
`endif

    cmp_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
